multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle control FSM that sequences the MIPS datapath around the shared register file, ALU and a single memory port. It issues one instruction at a time. It drives the register-file write controls (regWrite, regDst, jal, memToReg) and the PC, IR and memory controls, and it stalls on a memory-ready handshake. It also exports a retired-instruction counter and an illegal-opcode flag for debug and IO.

Parameters:
CNT_WIDTH, 32, width of retired-instruction counter.

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
run  in  1  1 = allow fetch of next instruction; sampled only in S_IF
opcode  in  6  instruction[31:26] from instruction register
funct  in  6  instruction[5:0] from instruction register
zero  in  1  ALU zero flag, valid in S_BR
memReady  in  1  memory/IO access complete this cycle
irWrite  out  1  load instruction register
pcWrite  out  1  load PC
pcSrc  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs (jr)
aluSrc  out  1  0 = readData2, 1 = extendedImm
aluOpSel  out  2  00 add (address), 01 sub (compare), 10 use funct, 11 use opcode (I-type)
memRead  out  1  data memory read strobe
memWrite  out  1  data memory write strobe
regWrite  out  1  register-file write enable
regDst  out  1  1 = rd, 0 = rt
jal  out  1  write link address to $31
memToReg  out  1  1 = write memData, 0 = aluResult
illegalOp  out  1  one-cycle pulse on an unsupported opcode
instrDone  out  1  one-cycle pulse when an instruction retires
retired  out  CNT_WIDTH  retired-instruction count
stateOut  out  4  current state encoding (debug)

Behaviour:
- States and encodings: S_IF=0, S_ID=1, S_EXA=2, S_MRD=3, S_MWR=4, S_WBM=5, S_EXR=6, S_WBR=7, S_BR=8, S_J=9, S_JAL=10, S_JR=11.
- Reset: state S_IF, all outputs 0, retired=0, latched opcode/funct=0. A reset in any state (including a pending MRD/MWR) returns to S_IF next cycle. The in-flight access is abandoned and no write is issued.
- All outputs are Moore outputs, decoded from the state and the opcode/funct latched in S_ID. Any output not listed for a state is 0.
- S_IF: if run=1, assert irWrite=1, pcWrite=1, pcSrc=00, then go to S_ID. If run=0, stay in S_IF with all strobes 0.
- S_ID: latch opcode/funct, then dispatch:
  - lw (100011) or sw (101011) -> S_EXA.
  - R-type (000000) with funct != 001000 -> S_EXR. R-type with funct 001000 (jr) -> S_JR.
  - I-ALU (001000, 001001, 001010, 001011, 001100, 001101, 001110, 001111) -> S_EXR.
  - beq (000100) or bne (000101) -> S_BR. j (000010) -> S_J. jal (000011) -> S_JAL.
  - Any other opcode: pulse illegalOp, go to S_IF, no retire.
- S_EXA: aluSrc=1, aluOpSel=00. Go to S_MRD for lw, S_MWR for sw.
- S_MRD: memRead=1, held until memReady=1, then S_WBM. No timeout.
- S_MWR: memWrite=1, held until memReady=1, then S_IF with instrDone=1.
- S_WBM: regWrite=1, memToReg=1, regDst=0, instrDone=1 -> S_IF.
- S_EXR: aluSrc=0 for R-type, 1 for I-ALU. aluOpSel=10 for R-type, 11 for I-ALU. Go to S_WBR.
- S_WBR: regWrite=1, memToReg=0, regDst=1 for R-type and 0 for I-ALU, instrDone=1 -> S_IF.
- S_BR: aluOpSel=01, pcSrc=01. pcWrite=(beq&zero)|(bne&~zero). instrDone=1 -> S_IF.
- S_J: pcWrite=1, pcSrc=10, instrDone=1 -> S_IF.
- S_JAL: pcWrite=1, pcSrc=10, regWrite=1, jal=1, instrDone=1 -> S_IF. The link value is PC+4, already in PC since S_IF.
- S_JR: pcWrite=1, pcSrc=11, instrDone=1 -> S_IF.
- Latency from S_IF to return to S_IF, with memReady=1 immediately:
  - R/I-ALU: 4 cycles. lw: 5 cycles. sw: 4 cycles. beq/bne/j/jal/jr: 3 cycles.
  - Each cycle memReady is low adds one cycle.
- regWrite is asserted for exactly one cycle per writing instruction and never together with memWrite.
- retired increments by 1 on every cycle instrDone=1 and wraps modulo 2^CNT_WIDTH.
- Changes to opcode/funct after S_ID have no effect until the next S_ID.

Test Plan:
- rst=1 for 2 cycles from any state -> stateOut=0, all strobes 0, retired=0. With run=0 held 10 cycles -> stays in S_IF, no irWrite.
- add (opcode 0, funct 100000), run=1 -> states 0,1,6,7,0. regWrite=1 with regDst=1 only in state 7. instrDone pulse. retired=1.
- lw (100011) with memReady low for 3 cycles in S_MRD -> memRead held 4 cycles. Then S_WBM has regWrite=1, memToReg=1, regDst=0. Total 8 cycles.
- beq with zero=1 -> pcWrite=1, pcSrc=01 in S_BR. bne with zero=1 -> pcWrite=0 in S_BR. Both retire in 3 cycles.
- jal (000011) -> S_JAL has pcWrite=1, pcSrc=10, regWrite=1, jal=1. jr (opcode 0, funct 001000) -> pcSrc=11, regWrite=0.
- opcode 111111 -> illegalOp pulses in S_ID, return to S_IF, retired unchanged. Reset asserted during S_MWR with memReady=0 -> next cycle S_IF, memWrite=0.
- Wrap check: CNT_WIDTH=4, 17 instructions retired -> retired=1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for a multi-cycle MIPS datapath. One instruction is in flight at
// a time. The FSM sequences fetch, decode, execute, memory and write-back
// around a shared register file, ALU and a single memory port. It stalls on
// memReady while a memory access is outstanding.
//
// Ports
//   clk        system clock, all state updates on posedge
//   rst        synchronous, active-high reset
//   run        allow fetch of the next instruction (sampled in S_IF only)
//   opcode     instruction[31:26] from the instruction register
//   funct      instruction[5:0] from the instruction register
//   zero       ALU zero flag, meaningful in S_BR
//   memReady   memory/IO access completes this cycle
//   irWrite    load instruction register
//   pcWrite    load PC
//   pcSrc      00 PC+4, 01 branch target, 10 jump target, 11 rs (jr)
//   aluSrc     0 readData2, 1 extendedImm
//   aluOpSel   00 add, 01 sub, 10 use funct, 11 use opcode
//   memRead    data memory read strobe
//   memWrite   data memory write strobe
//   regWrite   register-file write enable
//   regDst     1 rd, 0 rt
//   jal        write link address to $31
//   memToReg   1 memData, 0 aluResult
//   illegalOp  one-cycle pulse in decode on an unsupported opcode
//   instrDone  one-cycle pulse when an instruction retires
//   retired    retired-instruction count, wraps modulo 2^CNT_WIDTH
//   stateOut   current state encoding (debug)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic [5:0]           opcode,
   input  logic [5:0]           funct,
   input  logic                 zero,
   input  logic                 memReady,
   output logic                 irWrite,
   output logic                 pcWrite,
   output logic [1:0]           pcSrc,
   output logic                 aluSrc,
   output logic [1:0]           aluOpSel,
   output logic                 memRead,
   output logic                 memWrite,
   output logic                 regWrite,
   output logic                 regDst,
   output logic                 jal,
   output logic                 memToReg,
   output logic                 illegalOp,
   output logic                 instrDone,
   output logic [CNT_WIDTH-1:0] retired,
   output logic [3:0]           stateOut
);

   typedef enum logic [3:0] {
      S_IF  = 4'd0,
      S_ID  = 4'd1,
      S_EXA = 4'd2,
      S_MRD = 4'd3,
      S_MWR = 4'd4,
      S_WBM = 4'd5,
      S_EXR = 4'd6,
      S_WBR = 4'd7,
      S_BR  = 4'd8,
      S_J   = 4'd9,
      S_JAL = 4'd10,
      S_JR  = 4'd11
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   state_e                 state_q, state_d;
   logic [5:0]             opc_q, opc_d;
   logic [5:0]             funct_q, funct_d;
   logic [CNT_WIDTH-1:0]   retired_q, retired_d;

   // Decode of the live IR fields, used only while in S_ID.
   state_e                 id_next;
   logic                   id_legal;

   // Decode of the fields latched in S_ID, used by all later states.
   logic                   rtype_q;
   logic                   beq_q;

   // jr never reaches S_EXR/S_WBR, so the funct qualifier only tightens the
   // R-type decode; the I-ALU group is everything else that lands there.
   assign rtype_q = (opc_q == OP_RTYPE) && (funct_q != FN_JR);
   assign beq_q   = (opc_q == OP_BEQ);

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its neighbours, independent of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IF;
         opc_q     <= '0;
         funct_q   <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         opc_q     <= opc_d;
         funct_q   <= funct_d;
         retired_q <= retired_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Opcode dispatch for S_ID
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      id_next  = S_IF;
      id_legal = 1'b1;
      casez (opcode)
         OP_RTYPE:      id_next = (funct == FN_JR) ? S_JR : S_EXR;
         OP_LW, OP_SW:  id_next = S_EXA;
         6'b001???:     id_next = S_EXR;   // I-ALU group 001000..001111
         OP_BEQ, OP_BNE: id_next = S_BR;
         OP_J:          id_next = S_J;
         OP_JAL:        id_next = S_JAL;
         default:       id_legal = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      opc_d   = opc_q;
      funct_d = funct_q;
      case (state_q)
         S_IF:  if (run) state_d = S_ID;
         S_ID: begin
            opc_d   = opcode;
            funct_d = funct;
            state_d = id_next;
         end
         S_EXA: state_d = (opc_q == OP_SW) ? S_MWR : S_MRD;
         S_MRD: if (memReady) state_d = S_WBM;
         S_MWR: if (memReady) state_d = S_IF;
         S_EXR: state_d = S_WBR;
         default: state_d = S_IF;   // S_WBM, S_WBR, S_BR, S_J, S_JAL, S_JR
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output decode
   // ---------------------------------------------------------------------------
   // Outputs are forced low while rst is high so a reset landing on an
   // outstanding access never issues a strobe, even in its first cycle.
   always_comb begin
      irWrite   = 1'b0;
      pcWrite   = 1'b0;
      pcSrc     = 2'b00;
      aluSrc    = 1'b0;
      aluOpSel  = 2'b00;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      regWrite  = 1'b0;
      regDst    = 1'b0;
      jal       = 1'b0;
      memToReg  = 1'b0;
      illegalOp = 1'b0;
      instrDone = 1'b0;
      if (!rst) begin
         case (state_q)
            S_IF: begin
               irWrite = run;
               pcWrite = run;
            end
            S_ID:  illegalOp = !id_legal;
            S_EXA: aluSrc = 1'b1;
            S_MRD: memRead = 1'b1;
            S_MWR: begin
               memWrite  = 1'b1;
               instrDone = memReady;
            end
            S_WBM: begin
               regWrite  = 1'b1;
               memToReg  = 1'b1;
               instrDone = 1'b1;
            end
            S_EXR: begin
               aluSrc   = !rtype_q;
               aluOpSel = rtype_q ? 2'b10 : 2'b11;
            end
            S_WBR: begin
               regWrite  = 1'b1;
               regDst    = rtype_q;
               instrDone = 1'b1;
            end
            S_BR: begin
               aluOpSel  = 2'b01;
               pcSrc     = 2'b01;
               pcWrite   = beq_q ? zero : !zero;   // only beq/bne reach S_BR
               instrDone = 1'b1;
            end
            S_J: begin
               pcWrite   = 1'b1;
               pcSrc     = 2'b10;
               instrDone = 1'b1;
            end
            S_JAL: begin
               pcWrite   = 1'b1;
               pcSrc     = 2'b10;
               regWrite  = 1'b1;
               jal       = 1'b1;
               instrDone = 1'b1;
            end
            S_JR: begin
               pcWrite   = 1'b1;
               pcSrc     = 2'b11;
               instrDone = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign retired_d = instrDone ? retired_q + CNT_WIDTH'(1) : retired_q;
   assign retired   = retired_q;
   assign stateOut  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Drives directed and random instruction streams into multicycle_ctrl
// (CNT_WIDTH = 4) and compares every cycle's state, control outputs and
// retired count against a per-instruction-class reference model.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst, run, zero, memReady;
   logic [5:0]    opcode, funct;
   logic          irWrite, pcWrite, aluSrc, memRead, memWrite, regWrite;
   logic          regDst, jal, memToReg, illegalOp, instrDone;
   logic [1:0]    pcSrc, aluOpSel;
   logic [CW-1:0] retired;
   logic [3:0]    stateOut;

   typedef struct packed {
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       reg_dst;
      logic       jal;
      logic       mem_to_reg;
      logic       illegal;
      logic       done;
   } ctl_t;

   typedef enum {C_LW, C_SW, C_R, C_JR, C_I, C_BR, C_J, C_JAL, C_ILL} cls_e;

   ctl_t act;
   assign act = {irWrite, pcWrite, pcSrc, aluSrc, aluOpSel, memRead, memWrite,
                 regWrite, regDst, jal, memToReg, illegalOp, instrDone};

   int n_checks  = 0;
   int n_errors  = 0;
   int n_retired = 0;

   multicycle_ctrl #(.CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct(funct),
      .zero(zero), .memReady(memReady), .irWrite(irWrite), .pcWrite(pcWrite),
      .pcSrc(pcSrc), .aluSrc(aluSrc), .aluOpSel(aluOpSel), .memRead(memRead),
      .memWrite(memWrite), .regWrite(regWrite), .regDst(regDst), .jal(jal),
      .memToReg(memToReg), .illegalOp(illegalOp), .instrDone(instrDone),
      .retired(retired), .stateOut(stateOut)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle: inputs are already set; sample mid-cycle, then advance.
   task automatic cyc(input string tag, input logic [3:0] es, input ctl_t ec);
      @(negedge clk);
      check({tag, " state"}, 32'(stateOut), 32'(es));
      check({tag, " ctl"}, 32'(act), 32'(ec));
      check({tag, " retired"}, 32'(retired), 32'(n_retired % (1 << CW)));
      @(posedge clk);
      #1;
   endtask

   // Scramble every input the current state is supposed to ignore.
   task automatic noise();
      opcode   = 6'($urandom);
      funct    = 6'($urandom);
      zero     = 1'($urandom);
      memReady = 1'($urandom);
      run      = 1'($urandom);
   endtask

   function automatic cls_e classify(input logic [5:0] opc, input logic [5:0] fn);
      if (opc == 6'b100011)        return C_LW;
      if (opc == 6'b101011)        return C_SW;
      if (opc == 6'b000000)        return (fn == 6'b001000) ? C_JR : C_R;
      if (opc[5:3] == 3'b001)      return C_I;
      if (opc == 6'b000100 || opc == 6'b000101) return C_BR;
      if (opc == 6'b000010)        return C_J;
      if (opc == 6'b000011)        return C_JAL;
      return C_ILL;
   endfunction

   // Fetch + decode cycles shared by every instruction.
   task automatic front(input logic [5:0] opc, input logic [5:0] fn, input cls_e c);
      ctl_t e;
      noise();
      run = 1'b1;
      e = '0; e.ir_write = 1'b1; e.pc_write = 1'b1;
      cyc("IF", 4'd0, e);
      noise();
      opcode = opc;
      funct  = fn;
      e = '0; e.illegal = (c == C_ILL);
      cyc("ID", 4'd1, e);
   endtask

   task automatic do_instr(input logic [5:0] opc, input logic [5:0] fn,
                           input logic z, input int waits);
      ctl_t e;
      cls_e c;
      c = classify(opc, fn);
      front(opc, fn, c);
      noise();
      case (c)
         C_LW, C_SW: begin
            e = '0; e.alu_src = 1'b1;
            cyc("EXA", 4'd2, e);
            e = '0;
            if (c == C_LW) e.mem_read = 1'b1; else e.mem_write = 1'b1;
            for (int i = 0; i < waits; i++) begin
               noise();
               memReady = 1'b0;
               cyc(c == C_LW ? "MRD wait" : "MWR wait", c == C_LW ? 4'd3 : 4'd4, e);
            end
            noise();
            memReady = 1'b1;
            e.done = (c == C_SW);
            cyc(c == C_LW ? "MRD" : "MWR", c == C_LW ? 4'd3 : 4'd4, e);
            if (c == C_LW) begin
               noise();
               e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.done = 1'b1;
               cyc("WBM", 4'd5, e);
            end
            n_retired++;
         end
         C_R, C_I: begin
            e = '0;
            e.alu_src = (c == C_I);
            e.alu_op  = (c == C_I) ? 2'd3 : 2'd2;
            cyc("EXR", 4'd6, e);
            noise();
            e = '0; e.reg_write = 1'b1; e.reg_dst = (c == C_R); e.done = 1'b1;
            cyc("WBR", 4'd7, e);
            n_retired++;
         end
         C_BR: begin
            zero = z;
            e = '0; e.alu_op = 2'd1; e.pc_src = 2'd1; e.done = 1'b1;
            e.pc_write = (opc == 6'b000100) ? z : !z;
            cyc("BR", 4'd8, e);
            n_retired++;
         end
         C_J: begin
            e = '0; e.pc_write = 1'b1; e.pc_src = 2'd2; e.done = 1'b1;
            cyc("J", 4'd9, e);
            n_retired++;
         end
         C_JAL: begin
            e = '0; e.pc_write = 1'b1; e.pc_src = 2'd2; e.reg_write = 1'b1;
            e.jal = 1'b1; e.done = 1'b1;
            cyc("JAL", 4'd10, e);
            n_retired++;
         end
         C_JR: begin
            e = '0; e.pc_write = 1'b1; e.pc_src = 2'd3; e.done = 1'b1;
            cyc("JR", 4'd11, e);
            n_retired++;
         end
         default: ;   // illegal: already back in S_IF, nothing retires
      endcase
   endtask

   // Start a lw/sw, stall one cycle in the memory state, then reset.
   task automatic abort_mem(input logic is_sw);
      ctl_t e;
      logic [5:0] opc;
      opc = is_sw ? 6'b101011 : 6'b100011;
      front(opc, 6'($urandom), is_sw ? C_SW : C_LW);
      noise();
      e = '0; e.alu_src = 1'b1;
      cyc("ABT EXA", 4'd2, e);
      noise();
      memReady = 1'b0;
      e = '0;
      if (is_sw) e.mem_write = 1'b1; else e.mem_read = 1'b1;
      cyc("ABT mem", is_sw ? 4'd4 : 4'd3, e);
      memReady = 1'b0;
      rst = 1'b1;
      cyc("ABT rst", is_sw ? 4'd4 : 4'd3, '0);
      rst = 1'b0;
      run = 1'b0;
      n_retired = 0;
      cyc("ABT after", 4'd0, '0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         noise();
         run = 1'b0;
         cyc("IDLE", 4'd0, '0);
      end
   endtask

   initial begin
      logic [5:0] opc, fn;
      rst = 1'b1; run = 1'b0; opcode = '0; funct = '0; zero = 1'b0; memReady = 1'b0;
      @(posedge clk);
      #1;
      cyc("RST", 4'd0, '0);
      rst = 1'b0;

      idle(10);

      do_instr(6'b000000, 6'b100000, 1'b0, 0);   // add
      do_instr(6'b100011, 6'h00, 1'b0, 3);       // lw, 3 stall cycles
      do_instr(6'b101011, 6'h00, 1'b0, 2);       // sw, 2 stall cycles
      do_instr(6'b001101, 6'h15, 1'b0, 0);       // ori
      do_instr(6'b000100, 6'h00, 1'b1, 0);       // beq taken
      do_instr(6'b000101, 6'h00, 1'b1, 0);       // bne not taken
      do_instr(6'b000101, 6'h00, 1'b0, 0);       // bne taken
      do_instr(6'b000011, 6'h00, 1'b0, 0);       // jal
      do_instr(6'b000000, 6'b001000, 1'b0, 0);   // jr
      do_instr(6'b000010, 6'h00, 1'b0, 0);       // j
      do_instr(6'b111111, 6'h00, 1'b0, 0);       // illegal
      idle(2);

      abort_mem(1'b1);
      abort_mem(1'b0);

      // Counter wrap: 17 retirements on a 4-bit counter leaves 1.
      for (int i = 0; i < 17; i++) do_instr(6'b000010, 6'h00, 1'b0, 0);
      @(negedge clk);
      check("wrap retired", 32'(retired), 32'd1);
      @(posedge clk);
      #1;

      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 8))
            0: opc = 6'b100011;
            1: opc = 6'b101011;
            2: opc = 6'b000000;
            3: opc = {3'b001, 3'($urandom)};
            4: opc = 6'b000100;
            5: opc = 6'b000101;
            6: opc = 6'b000010;
            7: opc = 6'b000011;
            default: opc = 6'($urandom);
         endcase
         fn = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
         do_instr(opc, fn, 1'($urandom), $urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
